// File: rtl/ram_stream_reader.sv
// Streams LEN consecutive twoK_RAM words from START_ADDR onto a valid/ready port.
// Optional RD_CHECKSUM_EN adds an XOR checksum of all accepted words.
module ram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              issue;
  logic              push;
  logic              pop;
  logic              accept;
  logic [2:0]        occ;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    accept      = 1'b0;
    issue       = 1'b0;
    push        = inflight_q;
    pop         = (cnt_q != 2'd0) && out_ready;
    occ         = {2'b00, inflight_q} + {1'b0, cnt_q};

    if (push) begin
      fifo_d[wr_ptr_q] = ram_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      out_cnt_d = out_cnt_q - LEN_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          out_cnt_d = len;
          // an empty request still passes through DRAIN so done has a fixed latency
          if (len != '0) begin
            state_d     = S_READ;
            addr_d      = start_addr;
            issue_cnt_d = len;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_READ: begin
        // a word leaving this cycle frees a slot for the read issued now
        issue = (issue_cnt_q != '0) &&
                (occ < (pop ? 3'd3 : 3'd2));
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q - LEN_W'(1);
          if (issue_cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    inflight_d = issue;
    cnt_d      = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign ram_addr  = addr_q;
  assign ram_wr    = 1'b0;
  assign ram_wdata = '0;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];

`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept) checksum_d = '0;
    else if (pop) checksum_d = checksum_q ^ out_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader against a word-queue reference model.
// Define RD_CHECKSUM_EN to also check the checksum port.
module tb_ram_stream_reader;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef RD_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem [2048];
  logic [AW-1:0] addr_seen [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= mem[ram_addr];

  ram_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_wr     (ram_wr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef RD_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random
  task automatic run_xfer(input int a, input int l,
                          input int mode, input bit spurious);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] x;
    logic [DW-1:0] pd;
    logic [AW-1:0] last_addr;
    int n, idx, done_n, first_v, last_hs;
    bit pv, pr;
    x = '0;
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(mem[(a + i) % 2048]);
      x ^= mem[(a + i) % 2048];
    end
    addr_seen.delete();
    @(negedge clk);
    last_addr  = ram_addr;
    start      = 1'b1;
    start_addr = AW'(a);
    len        = LW'(l);
    out_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    n       = 1;
    idx     = 0;
    done_n  = -1;
    first_v = -1;
    last_hs = -1;
    pv      = 1'b0;
    pr      = 1'b0;
    pd      = '0;
    while (n < 40 + 4 * l) begin
      if (ram_wr !== 1'b0) chk("ram_wr", ram_wr, 0);
      if (ram_addr != last_addr) begin
        addr_seen.push_back(ram_addr);
        last_addr = ram_addr;
      end
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      if (out_valid && first_v < 0) first_v = n;
      if (done) begin
        done_n = n;
`ifdef RD_CHECKSUM_EN
        chk("checksum", checksum, x);
`endif
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n - 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        if (idx < l) chk("data", out_data, exp_q[idx]);
        else chk("extra_word", idx + 1, l);
        if (mode == 0) chk("thruput", n, 3 + idx);
        idx++;
        last_hs = n;
      end
      if (spurious && $urandom_range(0, 3) == 0) begin
        start      = 1'b1;
        start_addr = AW'($urandom);
        len        = LW'($urandom_range(1, 20));
      end else begin
        start = 1'b0;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("done_seen", done_n >= 0, 1);
    chk("word_count", idx, l);
    if (l == 0) begin
      chk("done_lat0", done_n, 2);
      chk("no_valid", first_v, -1);
    end else begin
      chk("done_lat", done_n, last_hs + 2);
      if (mode == 0) chk("first_lat", first_v, 3);
    end
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    logic [AW-1:0] a0;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;

    mem[1] = 32'h2000000B;
    mem[2] = 32'h12345678;
    run_xfer(1, 2, 0, 0);

    a0 = ram_addr;
    run_xfer(int'($urandom_range(0, 2047)), 0, 0, 0);
    chk("len0_addr", ram_addr, a0);

    mem[2046] = 32'hAAAA0001;
    mem[2047] = 32'hBBBB0002;
    mem[0]    = 32'hCCCC0003;
    mem[1]    = 32'hDDDD0004;
    run_xfer(2046, 4, 0, 0);
    if (addr_seen.size() >= 4) begin
      chk("wrap_a0", addr_seen[0], 2046);
      chk("wrap_a1", addr_seen[1], 2047);
      chk("wrap_a2", addr_seen[2], 0);
      chk("wrap_a3", addr_seen[3], 1);
    end else begin
      chk("wrap_addrs", addr_seen.size(), 4);
    end

    run_xfer(int'($urandom_range(0, 2047)), 8, 1, 0);

    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'($urandom);
    len        = 8;
    out_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || out_valid) begin
        chk("post_rst_done", done, 0);
        chk("post_rst_valid", out_valid, 0);
      end
    end
    chk("post_rst_quiet", {done, out_valid, busy}, 0);
    mem[0] = $urandom;
    run_xfer(0, 1, 0, 0);

`ifdef RD_CHECKSUM_EN
    mem[100] = 32'h1;
    mem[101] = 32'h2;
    mem[102] = 32'h4;
    mem[103] = 32'h8;
    run_xfer(100, 4, 2, 0);
`endif

    for (int t = 0; t < 12; t++) begin
      run_xfer(int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 24)),
               int'($urandom_range(0, 2)), 1'b1);
    end

    run_xfer(int'($urandom_range(0, 2047)), 2048, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
